// File: rtl/max_tree_pkg.sv
// Shared definitions for the max/argmax tree: width helpers, tie-break rule, accumulator states.
// Latency: n/a (package only).
// Backpressure: n/a.
package max_tree_pkg;

    // Ceiling log2, evaluated at elaboration time for tree depth and index widths.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width of the element-index field carried by every tree node.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // Width of the node any_valid flag.
    localparam int node_flag_w = 1;

    // Equal values keep the lower element index inside a beat and the earlier beat across beats.
    localparam bit tie_lower_wins = 1'b1;

    typedef enum logic {
        st_idle,
        st_acc
    } acc_state_t;

endpackage

// File: rtl/max_tree_idx_acc_if.sv
// Beat input bundle and group result bundle of the max/argmax accumulator.
// Latency: n/a (wiring only).
// Backpressure: none; the producer may present one beat per enabled cycle.
// Ports: master drives cmp_in* and receives cmp_out*; slave (the datapath) is the reverse.
interface max_tree_idx_acc_if #(
    parameter int cmp_input_n    = 8,
    parameter int cmp_width      = 8,
    parameter int beat_cnt_width = 8
);
    import max_tree_pkg::*;

    localparam int idx_w = idx_width(cmp_input_n);

    logic [cmp_input_n*cmp_width-1:0] cmp_in;
    logic [cmp_input_n-1:0]           cmp_in_mask;
    logic                             cmp_in_signed;
    logic                             cmp_in_last;
    logic                             cmp_in_vld;

    logic [cmp_width-1:0]             cmp_out;
    logic [idx_w-1:0]                 cmp_out_idx;
    logic [beat_cnt_width-1:0]        cmp_out_beat;
    logic                             cmp_out_none;
    logic                             cmp_out_ovf;
    logic                             cmp_out_vld;

    modport master (
        output cmp_in, cmp_in_mask, cmp_in_signed, cmp_in_last, cmp_in_vld,
        input  cmp_out, cmp_out_idx, cmp_out_beat, cmp_out_none, cmp_out_ovf, cmp_out_vld
    );

    modport slave (
        input  cmp_in, cmp_in_mask, cmp_in_signed, cmp_in_last, cmp_in_vld,
        output cmp_out, cmp_out_idx, cmp_out_beat, cmp_out_none, cmp_out_ovf, cmp_out_vld
    );

endinterface

// File: rtl/max_tree_node.sv
// One compare-select node of the max tree: forwards the larger valid child with its index.
// Latency: combinational.
// Backpressure: none.
// Ports: a/b values, a_idx/b_idx indices, a_v/b_v valid flags, signed_mode; y/y_idx/y_v result.
module max_tree_node
    import max_tree_pkg::*;
#(
    parameter int val_w = 8,
    parameter int idx_w = 3
) (
    input  logic [val_w-1:0] a,
    input  logic [val_w-1:0] b,
    input  logic [idx_w-1:0] a_idx,
    input  logic [idx_w-1:0] b_idx,
    input  logic             a_v,
    input  logic             b_v,
    input  logic             signed_mode,
    output logic [val_w-1:0] y,
    output logic [idx_w-1:0] y_idx,
    output logic             y_v
);

    logic b_gt;
    logic eq;
    logic pick_b;

    // Child a always covers the lower element indices, so a tie resolves toward a.
    always_comb begin
        b_gt   = signed_mode ? ($signed(b) > $signed(a)) : (b > a);
        eq     = (a == b);
        pick_b = b_v && (!a_v || b_gt || (eq && !tie_lower_wins));
        y      = pick_b ? b     : a;
        y_idx  = pick_b ? b_idx : a_idx;
        y_v    = a_v | b_v;
    end

endmodule

// File: rtl/max_tree_idx_acc.sv
// Pipelined masked max/argmax tree feeding a per-group accumulator; one result per group.
// Latency: P+1 enabled cycles from last beat to cmp_out_vld, P = ceil(log2(n)/levels_per_stage).
// Backpressure: none; accepts one beat per enabled cycle, aclken low freezes every register.
// Ports: aclk, aresetn (async active-low), aclken, bus (slave side of max_tree_idx_acc_if).
module max_tree_idx_acc
    import max_tree_pkg::*;
#(
    parameter int cmp_input_n      = 8,
    parameter int cmp_width        = 8,
    parameter int levels_per_stage = 2,
    parameter int beat_cnt_width   = 8,
    parameter int simulation_delay = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              aclken,
    max_tree_idx_acc_if.slave bus
);

    localparam int lv_n  = clog2(cmp_input_n);
    localparam int idx_w = idx_width(cmp_input_n);
    localparam int nodes = 2 * cmp_input_n - 1;
    localparam int fin   = nodes - 1;
    localparam int bw    = beat_cnt_width;

    // Registers here are plain edge-triggered; the delay parameter only has meaning in
    // behavioural models and is accepted so existing instantiations still elaborate.
    if (simulation_delay < 0) begin : g_neg_sim_delay
    end

    // Flattened tree: level l occupies [2n - (2n >> l), 2n - (2n >> (l+1))).
    logic [cmp_width-1:0] nd_val [nodes];
    logic [idx_w-1:0]     nd_idx [nodes];
    logic                 nd_v   [nodes];
    logic [lv_n:0]        sb_vld;
    logic [lv_n:0]        sb_last;
    logic [lv_n:0]        sb_sgn;

    for (genvar i = 0; i < cmp_input_n; i++) begin : g_leaf
        assign nd_val[i] = bus.cmp_in[i*cmp_width +: cmp_width];
        assign nd_idx[i] = idx_w'(i);
        assign nd_v[i]   = bus.cmp_in_mask[i];
    end
    assign sb_vld[0]  = bus.cmp_in_vld;
    assign sb_last[0] = bus.cmp_in_last;
    assign sb_sgn[0]  = bus.cmp_in_signed;

    for (genvar l = 1; l <= lv_n; l++) begin : g_lvl
        localparam int cnt    = cmp_input_n >> l;
        localparam int b_in   = 2 * cmp_input_n - ((2 * cmp_input_n) >> (l - 1));
        localparam int b_out  = 2 * cmp_input_n - ((2 * cmp_input_n) >> l);
        // A stage boundary after every levels_per_stage levels, and always after the root.
        localparam bit is_reg = ((l % levels_per_stage) == 0) || (l == lv_n);

        logic [cmp_width-1:0] c_val [cnt];
        logic [idx_w-1:0]     c_idx [cnt];
        logic                 c_v   [cnt];

        for (genvar j = 0; j < cnt; j++) begin : g_node
            max_tree_node #(
                .val_w (cmp_width),
                .idx_w (idx_w)
            ) u_node (
                .a           (nd_val[b_in + 2*j]),
                .b           (nd_val[b_in + 2*j + 1]),
                .a_idx       (nd_idx[b_in + 2*j]),
                .b_idx       (nd_idx[b_in + 2*j + 1]),
                .a_v         (nd_v[b_in + 2*j]),
                .b_v         (nd_v[b_in + 2*j + 1]),
                .signed_mode (sb_sgn[l-1]),
                .y           (c_val[j]),
                .y_idx       (c_idx[j]),
                .y_v         (c_v[j])
            );
        end

        if (is_reg) begin : g_reg
            logic [cmp_width-1:0] r_val [cnt];
            logic [idx_w-1:0]     r_idx [cnt];
            logic                 r_v   [cnt];
            logic                 r_vld;
            logic                 r_last;
            logic                 r_sgn;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_vld  <= 1'b0;
                    r_last <= 1'b0;
                    r_sgn  <= 1'b0;
                    for (int k = 0; k < cnt; k++) begin
                        r_val[k] <= '0;
                        r_idx[k] <= '0;
                        r_v[k]   <= 1'b0;
                    end
                end else if (aclken) begin
                    r_vld <= sb_vld[l-1];
                    if (sb_vld[l-1]) begin
                        r_last <= sb_last[l-1];
                        r_sgn  <= sb_sgn[l-1];
                        for (int k = 0; k < cnt; k++) begin
                            r_val[k] <= c_val[k];
                            r_idx[k] <= c_idx[k];
                            r_v[k]   <= c_v[k];
                        end
                    end
                end
            end

            for (genvar j = 0; j < cnt; j++) begin : g_out
                assign nd_val[b_out + j] = r_val[j];
                assign nd_idx[b_out + j] = r_idx[j];
                assign nd_v[b_out + j]   = r_v[j];
            end
            assign sb_vld[l]  = r_vld;
            assign sb_last[l] = r_last;
            assign sb_sgn[l]  = r_sgn;
        end else begin : g_comb
            for (genvar j = 0; j < cnt; j++) begin : g_out
                assign nd_val[b_out + j] = c_val[j];
                assign nd_idx[b_out + j] = c_idx[j];
                assign nd_v[b_out + j]   = c_v[j];
            end
            assign sb_vld[l]  = sb_vld[l-1];
            assign sb_last[l] = sb_last[l-1];
            assign sb_sgn[l]  = sb_sgn[l-1];
        end
    end

    // ------------------------------------------------------------------
    // Group accumulator
    // ------------------------------------------------------------------
    acc_state_t           state;
    logic [cmp_width-1:0] acc_val;
    logic [idx_w-1:0]     acc_idx;
    logic                 acc_v;
    logic [bw-1:0]        acc_beat;
    // One extra bit: reaching 2^bw means the incoming beat index no longer fits.
    logic [bw:0]          beat_cnt;
    logic                 ovf;

    logic [cmp_width-1:0] out_val_q;
    logic [idx_w-1:0]     out_idx_q;
    logic [bw-1:0]        out_beat_q;
    logic                 out_none_q;
    logic                 out_ovf_q;
    logic                 out_vld_q;

    logic                 beat_sat;
    logic [bw-1:0]        cur_beat;
    logic                 t_gt;
    logic                 take;
    logic [cmp_width-1:0] n_val;
    logic [idx_w-1:0]     n_idx;
    logic                 n_v;
    logic [bw-1:0]        n_beat;
    logic [bw:0]          n_cnt;
    logic                 n_ovf;

    always_comb begin
        beat_sat = beat_cnt[bw];
        cur_beat = beat_sat ? {bw{1'b1}} : beat_cnt[bw-1:0];
        t_gt     = sb_sgn[lv_n] ? ($signed(nd_val[fin]) > $signed(acc_val))
                                : (nd_val[fin] > acc_val);
        // Later beats must be strictly greater so the earliest occurrence is kept.
        take     = (state == st_idle) ||
                   (nd_v[fin] && (!acc_v || t_gt ||
                                  ((nd_val[fin] == acc_val) && !tie_lower_wins)));
        n_val    = take ? nd_val[fin] : acc_val;
        n_idx    = take ? nd_idx[fin] : acc_idx;
        n_v      = take ? nd_v[fin]   : acc_v;
        n_beat   = acc_beat;
        n_cnt    = beat_cnt;
        n_ovf    = ovf;
        if (state == st_idle) begin
            n_beat = '0;
            n_cnt  = (bw+1)'(1);
            n_ovf  = 1'b0;
        end else begin
            if (take) n_beat = cur_beat;
            if (!beat_sat) n_cnt = beat_cnt + (bw+1)'(1);
            n_ovf  = ovf | beat_sat;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= st_idle;
            acc_val    <= '0;
            acc_idx    <= '0;
            acc_v      <= 1'b0;
            acc_beat   <= '0;
            beat_cnt   <= '0;
            ovf        <= 1'b0;
            out_val_q  <= '0;
            out_idx_q  <= '0;
            out_beat_q <= '0;
            out_none_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_vld_q  <= 1'b0;
        end else if (aclken) begin
            out_vld_q <= 1'b0;
            if (sb_vld[lv_n]) begin
                acc_val  <= n_val;
                acc_idx  <= n_idx;
                acc_v    <= n_v;
                acc_beat <= n_beat;
                beat_cnt <= n_cnt;
                ovf      <= n_ovf;
                if (sb_last[lv_n]) begin
                    state      <= st_idle;
                    out_vld_q  <= 1'b1;
                    out_none_q <= !n_v;
                    out_ovf_q  <= n_ovf;
                    out_val_q  <= n_v ? n_val  : '0;
                    out_idx_q  <= n_v ? n_idx  : '0;
                    out_beat_q <= n_v ? n_beat : '0;
                end else begin
                    state <= st_acc;
                end
            end
        end
    end

    assign bus.cmp_out      = out_val_q;
    assign bus.cmp_out_idx  = out_idx_q;
    assign bus.cmp_out_beat = out_beat_q;
    assign bus.cmp_out_none = out_none_q;
    assign bus.cmp_out_ovf  = out_ovf_q;
    assign bus.cmp_out_vld  = out_vld_q;

endmodule

// File: tb/tb_max_tree_idx_acc.sv
// Directed bench for max_tree_idx_acc with a queue-based scoreboard and a decoupled monitor.
// dut_a: n=4, levels_per_stage=1, beat_cnt_width=8. dut_b: n=8, levels_per_stage=2, beat_cnt_width=2.
// Both configurations have a 3-cycle last-beat-to-result latency.
module tb_max_tree_idx_acc;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic aclken  = 1'b1;

    always #5 aclk = ~aclk;

    max_tree_idx_acc_if #(.cmp_input_n(4), .cmp_width(8), .beat_cnt_width(8)) bus_a ();
    max_tree_idx_acc_if #(.cmp_input_n(8), .cmp_width(8), .beat_cnt_width(2)) bus_b ();

    max_tree_idx_acc #(
        .cmp_input_n(4), .cmp_width(8), .levels_per_stage(1),
        .beat_cnt_width(8), .simulation_delay(1)
    ) dut_a (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .bus(bus_a)
    );

    max_tree_idx_acc #(
        .cmp_input_n(8), .cmp_width(8), .levels_per_stage(2),
        .beat_cnt_width(2), .simulation_delay(1)
    ) dut_b (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .bus(bus_b)
    );

    typedef struct {
        logic [7:0] val;
        logic [7:0] idx;
        logic [7:0] beat;
        logic       none;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_a;
    exp_t last_b;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic en_q   = 1'b0;

    always @(posedge aclk) begin
        cyc  <= cyc + 1;
        en_q <= aclken;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic observe(input int which, input logic [7:0] v, input logic [7:0] ix,
                           input logic [7:0] bt, input logic nn, input logic ov);
        exp_t e;
        exp_t got;
        got.val = v; got.idx = ix; got.beat = bt; got.none = nn; got.ovf = ov; got.cyc = cyc;
        if (!en_q) begin
            e = (which == 0) ? last_a : last_b;
            checks++;
            if ({v, ix, bt, nn, ov} !== {e.val, e.idx, e.beat, e.none, e.ovf}) begin
                errors++;
                $display("FAIL hold_%0d got %h/%0d/%0d/%b/%b want %h/%0d/%0d/%b/%b", which,
                         v, ix, bt, nn, ov, e.val, e.idx, e.beat, e.none, e.ovf);
            end
        end else begin
            if (which == 0) last_a = got; else last_b = got;
            checks++;
            if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_vld_%0d at cycle %0d got %h/%0d/%0d/%b/%b want no result",
                         which, cyc, v, ix, bt, nn, ov);
            end else begin
                e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
                if ({v, ix, bt, nn, ov} !== {e.val, e.idx, e.beat, e.none, e.ovf}) begin
                    errors++;
                    $display("FAIL result_%0d got %h/%0d/%0d/%b/%b want %h/%0d/%0d/%b/%b", which,
                             v, ix, bt, nn, ov, e.val, e.idx, e.beat, e.none, e.ovf);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency_%0d got cycle %0d want cycle %0d", which, cyc, e.cyc);
                end
            end
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            if (bus_a.cmp_out_vld)
                observe(0, bus_a.cmp_out, 8'(bus_a.cmp_out_idx), 8'(bus_a.cmp_out_beat),
                        bus_a.cmp_out_none, bus_a.cmp_out_ovf);
            if (bus_b.cmp_out_vld)
                observe(1, bus_b.cmp_out, 8'(bus_b.cmp_out_idx), 8'(bus_b.cmp_out_beat),
                        bus_b.cmp_out_none, bus_b.cmp_out_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_a(input logic [7:0] v, input logic [7:0] ix, input logic [7:0] bt,
                          input logic nn, input logic ov, input int extra);
        exp_t e;
        e.val = v; e.idx = ix; e.beat = bt; e.none = nn; e.ovf = ov; e.cyc = cyc + 3 + extra;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] v, input logic [7:0] ix, input logic [7:0] bt,
                          input logic nn, input logic ov);
        exp_t e;
        e.val = v; e.idx = ix; e.beat = bt; e.none = nn; e.ovf = ov; e.cyc = cyc + 3;
        q_b.push_back(e);
    endtask

    task automatic beat_a(input logic [31:0] d, input logic [3:0] m, input logic s, input logic l);
        bus_a.cmp_in        = d;
        bus_a.cmp_in_mask   = m;
        bus_a.cmp_in_signed = s;
        bus_a.cmp_in_last   = l;
        bus_a.cmp_in_vld    = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic beat_b(input logic [63:0] d, input logic [7:0] m, input logic s, input logic l);
        bus_b.cmp_in        = d;
        bus_b.cmp_in_mask   = m;
        bus_b.cmp_in_signed = s;
        bus_b.cmp_in_last   = l;
        bus_b.cmp_in_vld    = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic idle();
        bus_a.cmp_in_vld  = 1'b0;
        bus_a.cmp_in_last = 1'b0;
        bus_b.cmp_in_vld  = 1'b0;
        bus_b.cmp_in_last = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({bus_a.cmp_out, bus_a.cmp_out_idx, bus_a.cmp_out_beat, bus_a.cmp_out_none,
             bus_a.cmp_out_ovf, bus_a.cmp_out_vld} !== '0) begin
            errors++;
            $display("FAIL %s_a got %h/%0d/%0d/%b/%b/%b want all zero", nm, bus_a.cmp_out,
                     bus_a.cmp_out_idx, bus_a.cmp_out_beat, bus_a.cmp_out_none,
                     bus_a.cmp_out_ovf, bus_a.cmp_out_vld);
        end
        checks++;
        if ({bus_b.cmp_out, bus_b.cmp_out_idx, bus_b.cmp_out_beat, bus_b.cmp_out_none,
             bus_b.cmp_out_ovf, bus_b.cmp_out_vld} !== '0) begin
            errors++;
            $display("FAIL %s_b got %h/%0d/%0d/%b/%b/%b want all zero", nm, bus_b.cmp_out,
                     bus_b.cmp_out_idx, bus_b.cmp_out_beat, bus_b.cmp_out_none,
                     bus_b.cmp_out_ovf, bus_b.cmp_out_vld);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] bv;
        bus_a.cmp_in = '0; bus_a.cmp_in_mask = '0; bus_a.cmp_in_signed = 1'b0;
        bus_b.cmp_in = '0; bus_b.cmp_in_mask = '0; bus_b.cmp_in_signed = 1'b0;
        idle();
        wait_cyc(3);
        aresetn = 1'b1;
        check_zero("reset");

        // Single beat, unsigned then signed: elements {0x10,0xF0,0x20,0x30}.
        push_a(8'hF0, 1, 0, 0, 0, 0);
        beat_a({8'h30, 8'h20, 8'hF0, 8'h10}, 4'hF, 1'b0, 1'b1);
        idle(); wait_cyc(5);
        push_a(8'h30, 3, 0, 0, 0, 0);
        beat_a({8'h30, 8'h20, 8'hF0, 8'h10}, 4'hF, 1'b1, 1'b1);
        idle(); wait_cyc(5);

        // Three beats: {5,5,5,5}, {1,1,7,1}, {7,2,2,2}; the later tie must not replace.
        beat_a({8'd5, 8'd5, 8'd5, 8'd5}, 4'hF, 1'b0, 1'b0);
        beat_a({8'd1, 8'd7, 8'd1, 8'd1}, 4'hF, 1'b0, 1'b0);
        push_a(8'd7, 2, 1, 0, 0, 0);
        beat_a({8'd2, 8'd2, 8'd2, 8'd7}, 4'hF, 1'b0, 1'b1);
        idle(); wait_cyc(5);

        // Fully masked two-beat group.
        beat_a(32'h11223344, 4'b0000, 1'b0, 1'b0);
        push_a(8'h00, 0, 0, 1, 0, 0);
        beat_a(32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1);
        idle(); wait_cyc(5);

        // Mask 0b1010 on {9,3,9,4}.
        push_a(8'd4, 3, 0, 0, 0, 0);
        beat_a({8'd4, 8'd9, 8'd3, 8'd9}, 4'b1010, 1'b0, 1'b1);
        idle(); wait_cyc(5);

        // Mode change: unsigned 0x80 is beaten by signed 5 on the following beat.
        beat_a({8'd1, 8'd1, 8'd1, 8'h80}, 4'hF, 1'b0, 1'b0);
        push_a(8'd5, 0, 1, 0, 0, 0);
        beat_a({8'd0, 8'd0, 8'd0, 8'd5}, 4'hF, 1'b1, 1'b1);
        idle(); wait_cyc(5);

        // Masked first beat, valid second beat.
        beat_a(32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0);
        push_a(8'd3, 0, 1, 0, 0, 0);
        beat_a({8'd9, 8'd9, 8'd9, 8'd3}, 4'b0001, 1'b0, 1'b1);
        idle(); wait_cyc(5);

        // Tie inside one beat: {6,9,9,1} keeps index 1.
        push_a(8'd9, 1, 0, 0, 0, 0);
        beat_a({8'd1, 8'd9, 8'd9, 8'd6}, 4'hF, 1'b0, 1'b1);
        idle(); wait_cyc(5);

        // Two back-to-back single-beat groups in flight, then four frozen cycles.
        push_a(8'd4, 3, 0, 0, 0, 4);
        beat_a({8'd4, 8'd3, 8'd2, 8'd1}, 4'hF, 1'b0, 1'b1);
        push_a(8'h7F, 1, 0, 0, 0, 4);
        beat_a({8'd0, 8'd0, 8'h7F, 8'h80}, 4'hF, 1'b1, 1'b1);
        idle();
        aclken = 1'b0;
        wait_cyc(4);
        aclken = 1'b1;
        wait_cyc(6);

        // Freeze while a result strobe is high: outputs and vld must hold.
        push_a(8'h55, 2, 0, 0, 0, 0);
        beat_a({8'h01, 8'h55, 8'h02, 8'h03}, 4'hF, 1'b0, 1'b1);
        idle();
        wait_cyc(2);
        aclken = 1'b0;
        wait_cyc(2);
        aclken = 1'b1;
        wait_cyc(4);

        // Reset after two beats of a 0xFF group; nothing may come out for it.
        beat_a(32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
        beat_a(32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
        idle();
        aresetn = 1'b0;
        wait_cyc(1);
        aresetn = 1'b1;
        check_zero("midreset");
        wait_cyc(5);
        push_a(8'd3, 2, 0, 0, 0, 0);
        beat_a({8'd2, 8'd3, 8'd2, 8'd1}, 4'hF, 1'b0, 1'b1);
        idle(); wait_cyc(5);

        // dut_b: 6-beat group overflows a 2-bit beat index.
        for (int k = 0; k < 5; k++) begin
            bv = 8'(k + 1);
            beat_b({8{bv}}, 8'hFF, 1'b0, 1'b0);
        end
        push_b(8'h50, 6, 3, 0, 1);
        beat_b(64'h0050_0000_0000_0000, 8'hFF, 1'b0, 1'b1);
        idle(); wait_cyc(5);

        // dut_b: single beat, unsigned then signed, then masked.
        push_b(8'hEE, 5, 0, 0, 0);
        beat_b(64'h0706_EE04_0302_0100, 8'hFF, 1'b0, 1'b1);
        push_b(8'h07, 7, 0, 0, 0);
        beat_b(64'h0706_EE04_0302_0100, 8'hFF, 1'b1, 1'b1);
        push_b(8'h06, 6, 0, 0, 0);
        beat_b(64'h0706_EE04_0302_0100, 8'b0101_0000, 1'b0, 1'b1);
        idle(); wait_cyc(10);

        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL drain_a got %0d results outstanding want 0", q_a.size());
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL drain_b got %0d results outstanding want 0", q_b.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
